filtro_fir_mac: RTL and testbench
=================================

FILTRO_FIR_MAC -- requirements
Module: filtro_fir_mac

Interface
REQ-001 The block SHALL be clocked by one clock and use a synchronous, active-high reset: clk, rst.
REQ-002 The block SHALL have parameter COEF0..COEF7, default 12'sd256 each, Q1.11 signed tap coefficients; the default filter is an 8-tap average with unity DC gain.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port rx_listo  input  1  one-cycle strobe from the ADC receiver: a new sample is valid.
REQ-006 The block SHALL have port paquete_bits  input  12  ADC sample, unsigned offset binary: 0x800 = 0 V midpoint.
REQ-007 The block SHALL have port muestra_filtrada  output  12  filtered sample, signed two's complement.
REQ-008 The block SHALL have port dato_listo  output  1  one-cycle strobe: muestra_filtrada has been updated.
REQ-009 The block SHALL have port ocupado  output  1  high while a sample is being processed.
REQ-010 The block SHALL have port saturado  output  1  high when the last result was clipped; valid together with dato_listo and held until the next result.
REQ-011 The block SHALL have port muestra_perdida  output  1  sticky flag: a strobe arrived while busy; cleared only by rst.

Function
REQ-012 Sample conversion SHALL invert the MSB of paquete_bits, giving a signed value x in the range -2048..+2047.
REQ-013 The delay line SHALL be 8 signed 12-bit registers x[0..7], where x[0] is the newest sample.
REQ-014 The FSM SHALL have the states REPOSO, MAC and FIN.
REQ-015 In REPOSO, with rx_listo=1, on edge E0 the block SHALL shift the delay line (x[k] <= x[k-1], x[0] <= converted sample), clear the accumulator, set the tap index to 0 and go to MAC.
REQ-016 MAC SHALL run for exactly 8 cycles, one tap per cycle: acc <= acc + x[i]*COEFi for i = 0..7, in order.
REQ-017 Each product SHALL be a signed 24-bit value; the accumulator SHALL be signed 27 bits, so overflow is impossible.
REQ-018 After i=7 the FSM SHALL go to FIN; in FIN, r = acc arithmetically shifted right by 11 (floor).
REQ-019 If r > 2047 the output SHALL be 2047; if r < -2048 the output SHALL be -2048; in both cases saturado=1, otherwise saturado=0.
REQ-020 On the edge leaving FIN, the block SHALL register muestra_filtrada and saturado, pulse dato_listo high for exactly one cycle, and return to REPOSO.
REQ-021 Latency: dato_listo SHALL be high in the cycle after edge E0+10, i.e. 10 edges after the accepting edge.
REQ-022 ocupado SHALL be 1 in MAC and FIN and 0 in REPOSO, so throughput is at most 1 sample per 10 clocks.
REQ-023 rx_listo in MAC or FIN SHALL be ignored (no delay-line change) and SHALL set muestra_perdida.
REQ-024 rx_listo in the same cycle as the return to REPOSO SHALL be ignored; samples are accepted only while in REPOSO.
REQ-025 A rx_listo held high for several cycles SHALL be accepted once and then dropped per REQ-023.
REQ-026 muestra_filtrada SHALL hold its value between dato_listo pulses.

Reset
REQ-027 On rst=1 at a clock edge: the FSM SHALL go to REPOSO, and x[0..7], the accumulator, the tap index, muestra_filtrada, dato_listo, ocupado, saturado and muestra_perdida SHALL all be cleared to 0.
REQ-028 rst SHALL take priority over rx_listo, and a reset during MAC or FIN SHALL abort the computation with no dato_listo pulse.
REQ-029 The first rx_listo after reset is released SHALL be processed normally.

Verification
REQ-030 Reset: assert rst for 2 cycles -> all outputs 0; ocupado=0; idle 20 cycles -> dato_listo stays 0.
REQ-031 DC: 8 strobes of 0xC00, spaced by 12 cycles, default coefficients -> outputs 128, 256, 384, ..., 1024 (0x400); saturado=0; each dato_listo exactly 10 edges after its accepting edge.
REQ-032 Impulse: 0xFFF, then 9 samples of 0x800 -> output 255 eight times, then 0; a single 0x000 sample -> -256 eight times (floor).
REQ-033 Saturation: COEF0..7 = 1024; 8 samples of 0xFFF -> final result 2047 with saturado=1; 8 samples of 0x000 -> -2048 with saturado=1.
REQ-034 Busy drop: strobe, then another strobe 3 cycles later -> second strobe ignored; muestra_perdida=1 and stays 1; the first result is unaffected.
REQ-035 Mid-operation reset: rst during MAC cycle 4 -> no dato_listo; all state zero; a following 0xC00 strobe -> output 128.

Source files
------------

// File: rtl/filtro_fir_mac.sv
// filtro_fir_mac: 8-tap FIR filter for offset-binary ADC samples.
// One multiply-accumulate per clock, so each sample takes 10 cycles from
// the accepting edge to the dato_listo strobe. Strobes that arrive while
// busy are dropped and recorded in a sticky flag.
module filtro_fir_mac #(
  parameter logic signed [11:0] COEF0 = 12'sd256,
  parameter logic signed [11:0] COEF1 = 12'sd256,
  parameter logic signed [11:0] COEF2 = 12'sd256,
  parameter logic signed [11:0] COEF3 = 12'sd256,
  parameter logic signed [11:0] COEF4 = 12'sd256,
  parameter logic signed [11:0] COEF5 = 12'sd256,
  parameter logic signed [11:0] COEF6 = 12'sd256,
  parameter logic signed [11:0] COEF7 = 12'sd256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_listo,
  input  logic [11:0]        paquete_bits,
  output logic signed [11:0] muestra_filtrada,
  output logic               dato_listo,
  output logic               ocupado,
  output logic               saturado,
  output logic               muestra_perdida
);

  typedef enum logic [1:0] {REPOSO, MAC, FIN} estado_t;

  estado_t            r_estado;
  estado_t            w_estado_next;
  logic signed [11:0] r_x [8];          // delay line, r_x[0] is the newest sample
  logic signed [26:0] r_acc;            // wide enough that 8 full-scale products cannot overflow
  logic [2:0]         r_tap;
  logic               r_fin_paso;       // FIN takes two cycles: clamp, then publish
  logic signed [11:0] r_res;
  logic               r_sat_res;

  logic signed [11:0] w_muestra;
  logic signed [11:0] w_coef;
  logic signed [23:0] w_producto;
  logic signed [26:0] w_acc_desp;
  logic signed [11:0] w_res;
  logic               w_sat;

  // Offset binary to two's complement is just an MSB flip.
  assign w_muestra  = $signed({~paquete_bits[11], paquete_bits[10:0]});
  assign w_producto = r_x[r_tap] * w_coef;
  assign w_acc_desp = r_acc >>> 11;     // arithmetic shift gives floor for negatives
  assign ocupado    = (r_estado != REPOSO);

  // Coefficient selected by the current tap index.
  always_comb begin
    w_coef = COEF0;
    case (r_tap)
      3'd0: w_coef = COEF0;
      3'd1: w_coef = COEF1;
      3'd2: w_coef = COEF2;
      3'd3: w_coef = COEF3;
      3'd4: w_coef = COEF4;
      3'd5: w_coef = COEF5;
      3'd6: w_coef = COEF6;
      default: w_coef = COEF7;
    endcase
  end

  // Clamp the scaled accumulator into the 12-bit signed output range.
  always_comb begin
    w_res = w_acc_desp[11:0];
    w_sat = 1'b0;
    if (w_acc_desp > 27'sd2047) begin
      w_res = 12'sd2047;
      w_sat = 1'b1;
    end else if (w_acc_desp < -27'sd2048) begin
      w_res = -12'sd2048;
      w_sat = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_estado <= REPOSO;
    else     r_estado <= w_estado_next;
  end

  // Next-state logic: accept only in REPOSO, 8 MAC cycles, 2 FIN cycles.
  always_comb begin
    w_estado_next = r_estado;
    case (r_estado)
      REPOSO:  if (rx_listo) w_estado_next = MAC;
      MAC:     if (r_tap == 3'd7) w_estado_next = FIN;
      FIN:     if (r_fin_paso) w_estado_next = REPOSO;
      default: w_estado_next = REPOSO;
    endcase
  end

  // Datapath: delay line shift, multiply-accumulate, clamp and publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) r_x[k] <= '0;
      r_acc            <= '0;
      r_tap            <= '0;
      r_fin_paso       <= 1'b0;
      r_res            <= '0;
      r_sat_res        <= 1'b0;
      muestra_filtrada <= '0;
      dato_listo       <= 1'b0;
      saturado         <= 1'b0;
      muestra_perdida  <= 1'b0;
    end else begin
      dato_listo <= 1'b0;
      case (r_estado)
        REPOSO: begin
          if (rx_listo) begin
            for (int k = 7; k > 0; k--) r_x[k] <= r_x[k-1];
            r_x[0]     <= w_muestra;
            r_acc      <= '0;
            r_tap      <= '0;
            r_fin_paso <= 1'b0;
          end
        end
        MAC: begin
          r_acc <= r_acc + $signed({{3{w_producto[23]}}, w_producto});
          r_tap <= r_tap + 3'd1;
          if (rx_listo) muestra_perdida <= 1'b1;
        end
        FIN: begin
          if (!r_fin_paso) begin
            r_res      <= w_res;
            r_sat_res  <= w_sat;
            r_fin_paso <= 1'b1;
          end else begin
            muestra_filtrada <= r_res;
            saturado         <= r_sat_res;
            dato_listo       <= 1'b1;
          end
          if (rx_listo) muestra_perdida <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_fir_mac.sv
// Testbench for filtro_fir_mac: a default-coefficient instance and a
// COEF=1024 instance share the same stimulus and are both compared against
// an arithmetic model of the filter (sample history times coefficients).
module tb_filtro_fir_mac;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rx_listo = 1'b0;
  logic [11:0]        paquete_bits = 12'h800;
  logic signed [11:0] mf_d, mf_s;
  logic               dl_d, dl_s, oc_d, oc_s, sat_d, sat_s, mp_d, mp_s;

  int n_total = 0;
  int n_pass  = 0;
  int hist [8];

  always #5 clk = ~clk;

  filtro_fir_mac dut_d (
    .clk(clk), .rst(rst), .rx_listo(rx_listo), .paquete_bits(paquete_bits),
    .muestra_filtrada(mf_d), .dato_listo(dl_d), .ocupado(oc_d),
    .saturado(sat_d), .muestra_perdida(mp_d)
  );

  filtro_fir_mac #(
    .COEF0(12'sd1024), .COEF1(12'sd1024), .COEF2(12'sd1024), .COEF3(12'sd1024),
    .COEF4(12'sd1024), .COEF5(12'sd1024), .COEF6(12'sd1024), .COEF7(12'sd1024)
  ) dut_s (
    .clk(clk), .rst(rst), .rx_listo(rx_listo), .paquete_bits(paquete_bits),
    .muestra_filtrada(mf_s), .dato_listo(dl_s), .ocupado(oc_s),
    .saturado(sat_s), .muestra_perdida(mp_s)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: the sample's signed value is its offset-binary code minus 2048.
  task automatic model_push(input logic [11:0] s);
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'(s) - 2048;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) hist[k] = 0;
  endtask

  // Weighted sum, floor-divided by 2048, then clipped to 12-bit signed.
  task automatic model_out(input int cf, output int y, output int sat);
    longint acc = 0;
    longint r;
    for (int k = 0; k < 8; k++) acc += longint'(hist[k]) * longint'(cf);
    r = acc >>> 11;
    sat = 0;
    if (r > 2047)       begin y = 2047;  sat = 1; end
    else if (r < -2048) begin y = -2048; sat = 1; end
    else                y = int'(r);
  endtask

  // One transaction: rx_listo high for 'hold' edges plus an optional extra
  // strobe 'extra' edges after the accepting edge; watches 15 edges.
  task automatic send(input logic [11:0] s, input int hold, input int extra,
                      output int got_d, output int got_s, output int gsat_s);
    int fd, fs, pd, ps, ey, es, eys, ess;
    @(negedge clk);
    rx_listo = 1'b1;
    paquete_bits = s;
    model_push(s);
    model_out(256, ey, es);
    model_out(1024, eys, ess);
    fd = -1; fs = -1; pd = 0; ps = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      @(negedge clk);
      rx_listo = ((n + 1) < hold) || ((n + 1) == extra);
      if (n == 0) check("ocupado_tras_aceptar", {31'd0, oc_d}, 1);
      if (dl_d) begin pd++; if (fd < 0) fd = n; end
      if (dl_s) begin ps++; if (fs < 0) fs = n; end
    end
    check("latencia_d", fd, 10);
    check("latencia_s", fs, 10);
    check("pulsos_d", pd, 1);
    check("pulsos_s", ps, 1);
    check("valor_d", $signed(mf_d), ey);
    check("saturado_d", {31'd0, sat_d}, es);
    check("valor_s", $signed(mf_s), eys);
    check("saturado_s", {31'd0, sat_s}, ess);
    check("ocupado_reposo", {31'd0, oc_d}, 0);
    $display("tx muestra=0x%03h hold=%0d extra=%0d -> d=%0d(exp %0d) s=%0d(exp %0d) sat_s=%0d",
             s, hold, extra, $signed(mf_d), ey, $signed(mf_s), eys, sat_s);
    got_d = int'($signed(mf_d));
    got_s = int'($signed(mf_s));
    gsat_s = int'(sat_s);
  endtask

  initial begin
    int gd, gs, gss, pulses;
    logic [11:0] rs;
    model_clear();

    // Reset held for two edges: everything cleared.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mf_d", $signed(mf_d), 0);
    check("rst_dl_d", {31'd0, dl_d}, 0);
    check("rst_oc_d", {31'd0, oc_d}, 0);
    check("rst_sat_d", {31'd0, sat_d}, 0);
    check("rst_mp_d", {31'd0, mp_d}, 0);
    check("rst_mf_s", $signed(mf_s), 0);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (dl_d || dl_s) pulses++;
    end
    check("idle_sin_pulsos", pulses, 0);

    // DC ramp: each 0xC00 adds 128 with unit-gain averaging.
    for (int k = 0; k < 8; k++) begin
      send(12'hC00, 1, 0, gd, gs, gss);
      check("dc_rampa", gd, 128 * (k + 1));
    end

    // Flush with midscale, then positive and negative impulses.
    repeat (8) send(12'h800, 1, 0, gd, gs, gss);
    check("flush_cero", gd, 0);
    send(12'hFFF, 1, 0, gd, gs, gss);
    check("impulso_pos", gd, 255);
    for (int k = 1; k < 10; k++) begin
      send(12'h800, 1, 0, gd, gs, gss);
      check("impulso_pos_cola", gd, (k < 8) ? 255 : 0);
    end
    send(12'h000, 1, 0, gd, gs, gss);
    check("impulso_neg", gd, -256);
    for (int k = 1; k < 9; k++) begin
      send(12'h800, 1, 0, gd, gs, gss);
      check("impulso_neg_cola", gd, (k < 8) ? -256 : 0);
    end

    // Saturation on the high-gain instance at both rails.
    repeat (8) send(12'hFFF, 1, 0, gd, gs, gss);
    check("sat_pos_valor", gs, 2047);
    check("sat_pos_flag", gss, 1);
    repeat (8) send(12'h000, 1, 0, gd, gs, gss);
    check("sat_neg_valor", gs, -2048);
    check("sat_neg_flag", gss, 1);
    check("perdida_sin_drop", {31'd0, mp_d}, 0);

    // Second strobe 3 cycles into the computation is dropped.
    send(12'h9A5, 1, 3, gd, gs, gss);
    check("perdida_d", {31'd0, mp_d}, 1);
    check("perdida_s", {31'd0, mp_s}, 1);

    // Strobe held through the return to idle is accepted exactly once.
    send(12'h3C7, 11, 0, gd, gs, gss);
    check("perdida_sostenida", {31'd0, mp_d}, 1);

    // Random samples against the model.
    for (int k = 0; k < 20; k++) begin
      rs = 12'($urandom_range(0, 4095));
      send(rs, 1, 0, gd, gs, gss);
    end
    check("perdida_pegajosa", {31'd0, mp_d}, 1);

    // Reset in the middle of MAC aborts the computation.
    @(negedge clk);
    rx_listo = 1'b1;
    paquete_bits = 12'hE00;
    @(posedge clk);
    @(negedge clk);
    rx_listo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (dl_d || dl_s) pulses++;
    end
    check("abort_sin_pulso", pulses, 0);
    check("abort_mf_d", $signed(mf_d), 0);
    check("abort_sat_s", {31'd0, sat_s}, 0);
    check("abort_mp_d", {31'd0, mp_d}, 0);
    check("abort_oc_d", {31'd0, oc_d}, 0);
    send(12'hC00, 1, 0, gd, gs, gss);
    check("tras_abort_dc", gd, 128);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
